piso_serializer: RTL

- Parallel-in, serial-out transmitter. Accepts one WIDTH-bit word through a valid/ready handshake and drives it out MSB-first, one bit per clock.
- It is the transmit end of the lab's single-bit serial link. The matching capture side is a chain of D flip-flops at the receiver.
- Frames can run back-to-back with no idle cycle between them.

---
 rtl/serial_pkg.sv | 17 +
 rtl/piso_shift_reg.sv | 27 ++
 rtl/piso_serializer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial link blocks.
// Parity support is built only when PISO_PARITY_EN is defined.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PAR
    } state_t;

    localparam int MAX_WIDTH = 32;

    function automatic logic even_parity(input logic [MAX_WIDTH-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// MSB-first shift register; a load wins over a shift on the same edge.
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             msb
);

    logic [WIDTH-1:0] shreg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= d;
        end else if (shift) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = shreg[WIDTH-1];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter, MSB first, gapless frames.
// Define PISO_PARITY_EN to append an even-parity bit to each frame.
module piso_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            armed;
    logic            msb;
    logic            last_bit;
    logic            accept;
    logic            cnt_zero;

    assign cnt_zero = (cnt == '0);

`ifdef PISO_PARITY_EN
    logic                 par;
    logic [MAX_WIDTH-1:0] ext;

    always_comb begin
        ext = '0;
        ext[WIDTH-1:0] = in_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par <= 1'b0;
        end else if (accept) begin
            par <= even_parity(ext);
        end
    end

    assign last_bit = (state == PAR);
`else
    assign last_bit = (state == SHIFT) && cnt_zero;
`endif

    // armed holds in_ready low until the first edge after reset
    assign in_ready = armed && ((state == IDLE) || last_bit);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);

    piso_shift_reg #(
        .WIDTH(WIDTH)
    ) u_shreg (
        .clk  (clk),
        .reset(reset),
        .load (accept),
        .shift((state == SHIFT) && !accept),
        .d    (in_data),
        .msb  (msb)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (accept) begin
                state <= SHIFT;
                cnt   <= CW'(WIDTH - 1);
            end else begin
                unique case (state)
                    SHIFT: begin
                        if (cnt_zero) begin
`ifdef PISO_PARITY_EN
                            state <= PAR;
`else
                            state <= IDLE;
`endif
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    PAR:     state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        sout       = 1'b0;
        sout_valid = 1'b0;
        sout_last  = 1'b0;
        unique case (state)
            SHIFT: begin
                sout       = msb;
                sout_valid = 1'b1;
`ifndef PISO_PARITY_EN
                sout_last  = cnt_zero;
`endif
            end
`ifdef PISO_PARITY_EN
            PAR: begin
                sout       = par;
                sout_valid = 1'b1;
                sout_last  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule
